// File: rtl/nic_output_packetizer_pkg.sv
// Shared constants and FSM state type for the NIC output packetizer slice.
// NIC_CHANNEL_WIDTH stands in for the CHANNEL_WIDTH macro formerly pulled from system.vh.
package nic_output_packetizer_pkg;

    localparam int unsigned NIC_CHANNEL_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/nic_output_packetizer_if.sv
// Bundle of the packetizer's PE-side and router-side signals for harnesses and integration wrappers.
// master drives results and credits; slave is the packetizer side.
interface nic_output_packetizer_if
    import nic_output_packetizer_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = NIC_CHANNEL_WIDTH,
    parameter int unsigned RESULT_WORDS  = 2
) ();

    logic                                    done_strobe_din;
    logic [2*CHANNEL_WIDTH*RESULT_WORDS-1:0] result_din;
    logic [CHANNEL_WIDTH-1:0]                shifted_header_din;
    logic                                    ready_dout;
    logic                                    zero_credits_dout;
    logic                                    overflow_dout;
    logic                                    credit_in_din;
    logic [CHANNEL_WIDTH-1:0]                output_channel_dout;

    modport master (
        output done_strobe_din, result_din, shifted_header_din, credit_in_din,
        input  ready_dout, zero_credits_dout, overflow_dout, output_channel_dout
    );

    modport slave (
        input  done_strobe_din, result_din, shifted_header_din, credit_in_din,
        output ready_dout, zero_credits_dout, overflow_dout, output_channel_dout
    );

endinterface

// File: rtl/nic_result_fifo.sv
// Small power-of-two FIFO holding {header, result} packets; push while full and pop while empty are ignored.
// Storage is intentionally not reset, only the pointers and count.
module nic_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nic_output_packetizer.sv
// Serialises queued PE results into header + data flits toward the router under credit flow control.
// Flat ports are kept for drop-in use; nic_output_packetizer_if bundles the same signals for wrappers.
module nic_output_packetizer
    import nic_output_packetizer_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = NIC_CHANNEL_WIDTH,
    parameter int unsigned RESULT_WORDS  = 2,
    parameter int unsigned QUEUE_DEPTH   = 2,
    parameter int unsigned BUFFER_DEPTH  = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    done_strobe_din,
    input  logic [2*CHANNEL_WIDTH*RESULT_WORDS-1:0] result_din,
    input  logic [CHANNEL_WIDTH-1:0]                shifted_header_din,
    output logic                                    ready_dout,
    output logic                                    zero_credits_dout,
    output logic                                    overflow_dout,
    input  logic                                    credit_in_din,
    output logic [CHANNEL_WIDTH-1:0]                output_channel_dout
);

    localparam int unsigned FLITS = 2 * RESULT_WORDS;
    localparam int unsigned RW    = 2 * CHANNEL_WIDTH * RESULT_WORDS;
    localparam int unsigned QW    = CHANNEL_WIDTH + RW;
    localparam int unsigned IW    = $clog2(FLITS + 1);
    localparam int unsigned CRW   = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned CNTW  = $clog2(QUEUE_DEPTH) + 1;

    pkt_state_t          state;
    logic [IW-1:0]       idx;
    logic [CRW-1:0]      credits;

    logic [QW-1:0]       q_dout;
    logic [RW-1:0]       q_res;
    logic [CHANNEL_WIDTH-1:0] q_hdr;
    logic                q_full;
    logic                q_empty;
    logic [CNTW-1:0]     q_count;

    logic                push_acc;
    logic                has_credit;
    logic                send;
    logic                pop;
    logic                more_queued;
    logic                credit_after;
    logic [CHANNEL_WIDTH-1:0] flit_next;
    logic [CHANNEL_WIDTH-1:0] flits [FLITS+1];

    nic_result_fifo #(
        .WIDTH (QW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (done_strobe_din),
        .pop   (pop),
        .din   ({shifted_header_din, result_din}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign q_hdr = q_dout[QW-1 -: CHANNEL_WIDTH];
    assign q_res = q_dout[RW-1:0];

    // Flit index 0 is the header; index j>0 is the (j-1)th CHANNEL_WIDTH slice of the result.
    assign flits[0] = q_hdr;
    for (genvar j = 0; j < FLITS; j++) begin : g_flit
        assign flits[j+1] = q_res[j*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end

    assign push_acc          = done_strobe_din & ~q_full;
    assign has_credit        = (credits != '0);
    assign more_queued       = (q_count > CNTW'(1)) || push_acc;
    assign credit_after      = (credits > CRW'(1)) || credit_in_din;
    assign ready_dout        = ~q_full;
    assign zero_credits_dout = ~has_credit;

    always_comb begin
        send      = 1'b0;
        pop       = 1'b0;
        flit_next = '0;
        case (state)
            IDLE: begin
                if (!q_empty && has_credit) begin
                    send      = 1'b1;
                    flit_next = q_hdr;
                end
            end
            SEND: begin
                if (has_credit) begin
                    send      = 1'b1;
                    flit_next = flits[idx];
                    pop       = (idx == IW'(FLITS));
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            idx                 <= '0;
            credits             <= CRW'(BUFFER_DEPTH);
            output_channel_dout <= '0;
            overflow_dout       <= 1'b0;
        end else begin
            output_channel_dout <= flit_next;
            if (done_strobe_din && q_full) overflow_dout <= 1'b1;

            case ({send, credit_in_din})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   if (credits != CRW'(BUFFER_DEPTH)) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase

            case (state)
                IDLE: begin
                    if (send) begin
                        state <= SEND;
                        idx   <= IW'(1);
                    end
                end
                SEND: begin
                    if (send && pop) begin
                        // Chain straight into the next header when the following packet can go out.
                        idx   <= '0;
                        state <= (more_queued && credit_after) ? SEND : IDLE;
                    end else if (send) begin
                        idx <= idx + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nic_output_packetizer.sv
// Directed bench for nic_output_packetizer: a per-cycle vector table plus hand-written corner sequences.
module tb_nic_output_packetizer;
    import nic_output_packetizer_pkg::*;

    localparam int unsigned CW = 32;
    localparam int unsigned W  = 2;
    localparam int unsigned NV = 29;

    localparam logic [127:0] R1 = {64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444};
    localparam logic [127:0] R2 = {64'hBBBB_CCCC_DDDD_EEEE, 64'h0123_4567_89AB_CDEF};
    localparam logic [127:0] R3 = {64'hFEED_0004_FEED_0003, 64'hFEED_0002_FEED_0001};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nic_output_packetizer_if #(.CHANNEL_WIDTH(CW), .RESULT_WORDS(W)) bus ();

    nic_output_packetizer #(
        .CHANNEL_WIDTH (CW),
        .RESULT_WORDS  (W),
        .QUEUE_DEPTH   (2),
        .BUFFER_DEPTH  (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .done_strobe_din     (bus.done_strobe_din),
        .result_din          (bus.result_din),
        .shifted_header_din  (bus.shifted_header_din),
        .ready_dout          (bus.ready_dout),
        .zero_credits_dout   (bus.zero_credits_dout),
        .overflow_dout       (bus.overflow_dout),
        .credit_in_din       (bus.credit_in_din),
        .output_channel_dout (bus.output_channel_dout)
    );

    typedef struct {
        logic         strobe;
        logic [31:0]  hdr;
        logic [127:0] res;
        logic         ci;
        logic [31:0]  exp_out;
        logic         exp_ready;
        logic         exp_zero;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs [NV];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic [31:0] h, input logic [127:0] r, input logic c);
        bus.done_strobe_din    = s;
        bus.shifted_header_din = h;
        bus.result_din         = r;
        bus.credit_in_din      = c;
    endtask

    function automatic vec_t mk(input logic s, input logic [31:0] h, input logic [127:0] r,
                                input logic c, input logic [31:0] o, input logic z);
        vec_t v;
        v.strobe = s; v.hdr = h; v.res = r; v.ci = c;
        v.exp_out = o; v.exp_ready = 1'b1; v.exp_zero = z; v.exp_ovf = 1'b0;
        return v;
    endfunction

    logic [31:0] seq [12];

    initial begin
        // single packet, credit exhaustion, one-credit release, coincident credit, saturation
        vecs[0]  = mk(1, 32'hA5, R1, 0, 32'h0,        0);
        vecs[1]  = mk(0, 0, 0, 0, 32'hA5,             0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h3333_4444,      0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h1111_2222,      0);
        vecs[4]  = mk(0, 0, 0, 0, 32'h7777_8888,      0);
        vecs[5]  = mk(0, 0, 0, 0, 32'h5555_6666,      1);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,              1);
        vecs[7]  = mk(1, 32'h5A, R2, 0, 32'h0,        1);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,              1);
        vecs[9]  = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[10] = mk(0, 0, 0, 0, 32'h5A,             1);
        vecs[11] = mk(0, 0, 0, 0, 32'h0,              1);
        vecs[12] = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[13] = mk(0, 0, 0, 1, 32'h89AB_CDEF,      0);
        vecs[14] = mk(0, 0, 0, 1, 32'h0123_4567,      0);
        vecs[15] = mk(0, 0, 0, 1, 32'hDDDD_EEEE,      0);
        vecs[16] = mk(0, 0, 0, 1, 32'hBBBB_CCCC,      0);
        vecs[17] = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[18] = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[19] = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[20] = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[21] = mk(0, 0, 0, 1, 32'h0,              0);
        vecs[22] = mk(1, 32'h3C, R3, 0, 32'h0,        0);
        vecs[23] = mk(0, 0, 0, 0, 32'h3C,             0);
        vecs[24] = mk(0, 0, 0, 0, 32'hFEED_0001,      0);
        vecs[25] = mk(0, 0, 0, 0, 32'hFEED_0002,      0);
        vecs[26] = mk(0, 0, 0, 0, 32'hFEED_0003,      0);
        vecs[27] = mk(0, 0, 0, 0, 32'hFEED_0004,      1);
        vecs[28] = mk(0, 0, 0, 0, 32'h0,              1);

        reset = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_out",   bus.output_channel_dout, 32'h0);
        chk("reset_ready", 32'(bus.ready_dout), 32'd1);
        chk("reset_zero",  32'(bus.zero_credits_dout), 32'd0);
        chk("reset_ovf",   32'(bus.overflow_dout), 32'd0);
        reset = 1'b1;

        for (int unsigned i = 0; i < NV; i++) begin
            drive(vecs[i].strobe, vecs[i].hdr, vecs[i].res, vecs[i].ci);
            step();
            chk($sformatf("vec%0d_out", i),   bus.output_channel_dout, vecs[i].exp_out);
            chk($sformatf("vec%0d_ready", i), 32'(bus.ready_dout), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_zero", i),  32'(bus.zero_credits_dout), 32'(vecs[i].exp_zero));
            chk($sformatf("vec%0d_ovf", i),   32'(bus.overflow_dout), 32'(vecs[i].exp_ovf));
        end

        // overflow: credits are 0 here, so three strobes fill the queue and the third is dropped
        drive(1, 32'h11, R1, 0); step();
        chk("ovf_ready1", 32'(bus.ready_dout), 32'd1);
        drive(1, 32'h12, R1, 0); step();
        chk("ovf_ready2", 32'(bus.ready_dout), 32'd0);
        drive(1, 32'h13, R1, 0); step();
        chk("ovf_set", 32'(bus.overflow_dout), 32'd1);
        drive(0, 0, 0, 0); step();
        chk("ovf_sticky", 32'(bus.overflow_dout), 32'd1);

        seq = '{32'h0, 32'h11, 32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666,
                32'h12, 32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666, 32'h0};
        drive(0, 0, 0, 1);
        for (int unsigned i = 0; i < 12; i++) begin
            step();
            chk($sformatf("drain%0d", i), bus.output_channel_dout, seq[i]);
        end
        chk("ovf_still", 32'(bus.overflow_dout), 32'd1);

        reset = 1'b0;
        #1;
        chk("rst2_ovf",   32'(bus.overflow_dout), 32'd0);
        chk("rst2_ready", 32'(bus.ready_dout), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        // back-to-back: second strobe two cycles after the first, credits returned every cycle
        seq = '{32'h0, 32'hA5, 32'h3333_4444, 32'h1111_2222, 32'h7777_8888, 32'h5555_6666,
                32'h5A, 32'h89AB_CDEF, 32'h0123_4567, 32'hDDDD_EEEE, 32'hBBBB_CCCC, 32'h0};
        for (int unsigned i = 0; i < 12; i++) begin
            if (i == 0)      drive(1, 32'hA5, R1, 1);
            else if (i == 2) drive(1, 32'h5A, R2, 1);
            else             drive(0, 0, 0, 1);
            step();
            chk($sformatf("b2b%0d", i), bus.output_channel_dout, seq[i]);
            if (i == 2) chk("b2b_ready_low",  32'(bus.ready_dout), 32'd0);
            if (i == 5) chk("b2b_ready_high", 32'(bus.ready_dout), 32'd1);
        end

        // reset mid-packet while the third flit is on the channel
        drive(1, 32'h77, R3, 0); step();
        drive(0, 0, 0, 0); step(); step(); step();
        chk("mid_flit3", bus.output_channel_dout, 32'hFEED_0002);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out",   bus.output_channel_dout, 32'h0);
        chk("mid_rst_zero",  32'(bus.zero_credits_dout), 32'd0);
        chk("mid_rst_ready", 32'(bus.ready_dout), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            chk($sformatf("post_rst%0d", i), bus.output_channel_dout, 32'h0);
        end

        // credits restored to 5: a fresh packet goes out in full and exhausts them
        seq = '{32'h0, 32'h99, 32'hFEED_0001, 32'hFEED_0002, 32'hFEED_0003, 32'hFEED_0004,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int unsigned i = 0; i < 7; i++) begin
            if (i == 0) drive(1, 32'h99, R3, 0);
            else        drive(0, 0, 0, 0);
            step();
            chk($sformatf("refill%0d", i), bus.output_channel_dout, seq[i]);
        end
        chk("refill_zero", 32'(bus.zero_credits_dout), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
